// File: rtl/dmp_pkg.sv
// CSR selector encodings and domain-switch FSM states for dmp_cfg_regs.
package dmp_pkg;

    localparam logic [1:0] SEL_PMPADDR = 2'd0;
    localparam logic [1:0] SEL_PMPCFG  = 2'd1;
    localparam logic [1:0] SEL_DMPCFG  = 2'd2;
    localparam logic [1:0] SEL_EXPDOM  = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DRAIN,
        ST_SWITCH
    } dsw_state_t;

    // R=0 with W=1 is a reserved pmpcfg permission encoding.
    function automatic logic cfg_is_reserved(input logic [7:0] cfg);
        return (cfg[1:0] == 2'b10);
    endfunction

endpackage

// File: rtl/riscv_pkg.sv
// RISC-V PMP/DMP configuration types shared by the config stage and the checker.
package riscv_pkg;

    typedef enum logic [1:0] {
        OFF   = 2'b00,
        TOR   = 2'b01,
        NA4   = 2'b10,
        NAPOT = 2'b11
    } pmp_addr_mode_t;

    typedef struct packed {
        logic x;
        logic w;
        logic r;
    } pmpcfg_access_t;

    typedef struct packed {
        logic           locked;
        logic [1:0]     reserved;
        pmp_addr_mode_t addr_mode;
        pmpcfg_access_t access_type;
    } pmpcfg_t;

    typedef enum logic [1:0] {
        DOM0 = 2'd0,
        DOM1 = 2'd1,
        DOM2 = 2'd2,
        DOMI = 2'd3
    } dmp_domain_t;

    typedef struct packed {
        dmp_domain_t domain;
    } dmpcfg_t;

endpackage

// File: rtl/dmp_outstanding_cnt.sv
// Saturating up/down count of in-flight memory accesses, with a zero flag.
module dmp_outstanding_cnt #(
    parameter int CNT_W = 4
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic inc_i,
    input  logic dec_i,
    output logic zero_o
);

    logic [CNT_W-1:0] cnt_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else if (inc_i && !dec_i && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_q <= cnt_q + 1'b1;
        end else if (dec_i && !inc_i && (cnt_q != '0)) begin
            cnt_q <= cnt_q - 1'b1;
        end
    end

    assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/dmp_cfg_regs.sv
// PMP/DMP config registers and sequenced execution-domain switch.
// Optional drain timeout enabled by defining DMP_DRAIN_TIMEOUT_EN.
module dmp_cfg_regs
    import riscv_pkg::*;
    import dmp_pkg::*;
#(
    parameter int NR_ENTRIES = 1,
    parameter int PMP_LEN    = 13,
    parameter int CNT_W      = 4
`ifdef DMP_DRAIN_TIMEOUT_EN
    , parameter int TIMEOUT  = 255
`endif
) (
    input  logic                                  clk_i,
    input  logic                                  rst_i,
    input  logic                                  csr_valid_i,
    input  logic                                  csr_we_i,
    input  logic [1:0]                            csr_sel_i,
    input  logic [$clog2(NR_ENTRIES > 1 ? NR_ENTRIES : 2)-1:0] csr_idx_i,
    input  logic [PMP_LEN-1:0]                    csr_wdata_i,
    output logic                                  csr_ready_o,
    output logic [PMP_LEN-1:0]                    csr_rdata_o,
    output logic                                  csr_rvalid_o,
    output logic                                  csr_err_o,
    input  logic                                  dsw_valid_i,
    input  dmp_domain_t                           dsw_dom_i,
    output logic                                  dsw_ready_o,
`ifdef DMP_DRAIN_TIMEOUT_EN
    output logic                                  dsw_timeout_o,
`endif
    input  logic                                  mem_req_i,
    input  logic                                  mem_rsp_i,
    output logic [NR_ENTRIES*PMP_LEN-1:0]         conf_addr_o,
    output pmpcfg_t [NR_ENTRIES-1:0]              pmpconf_o,
    output dmpcfg_t [NR_ENTRIES-1:0]              dmpconf_o,
    output dmp_domain_t                           expdom_o
);

    dsw_state_t          state_q, state_d;
    dmp_domain_t         expdom_q, dom_q;
    logic [PMP_LEN-1:0]  addr_q [NR_ENTRIES];
    pmpcfg_t             cfg_q  [NR_ENTRIES];
    dmpcfg_t             dmp_q  [NR_ENTRIES];
    logic [NR_ENTRIES-1:0] tor_lock;
    logic [PMP_LEN-1:0]  rd_val;
    logic                idx_ok, wr_block, err_c, accept;
    logic                cnt_zero, drain_done, timeout_hit;

    dmp_outstanding_cnt #(.CNT_W(CNT_W)) u_cnt (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .inc_i (mem_req_i),
        .dec_i (mem_rsp_i),
        .zero_o(cnt_zero)
    );

    // A locked TOR entry also protects the pmpaddr below it, since that is its base.
    always_comb begin
        tor_lock = '0;
        for (int i = 0; i < NR_ENTRIES - 1; i++) begin
            tor_lock[i] = cfg_q[i+1].locked && (cfg_q[i+1].addr_mode == TOR);
        end
    end

    always_comb begin
        idx_ok   = (int'(csr_idx_i) < NR_ENTRIES);
        rd_val   = '0;
        wr_block = 1'b0;
        if (idx_ok) begin
            case (csr_sel_i)
                SEL_PMPADDR: begin
                    rd_val   = addr_q[csr_idx_i];
                    wr_block = cfg_q[csr_idx_i].locked || tor_lock[csr_idx_i];
                end
                SEL_PMPCFG: begin
                    rd_val   = {{(PMP_LEN-8){1'b0}}, cfg_q[csr_idx_i]};
                    wr_block = cfg_q[csr_idx_i].locked || cfg_is_reserved(csr_wdata_i[7:0]);
                end
                SEL_DMPCFG: begin
                    rd_val   = {{(PMP_LEN-2){1'b0}}, dmp_q[csr_idx_i]};
                    wr_block = cfg_q[csr_idx_i].locked;
                end
                default: begin
                    rd_val   = {{(PMP_LEN-2){1'b0}}, expdom_q};
                    wr_block = 1'b1;
                end
            endcase
        end
        err_c = !idx_ok || (csr_we_i && wr_block);
    end

    assign csr_ready_o = (state_q != ST_SWITCH);
    assign accept      = csr_valid_i && csr_ready_o;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < NR_ENTRIES; i++) begin
                addr_q[i] <= '0;
                cfg_q[i]  <= '0;
                dmp_q[i]  <= '{domain: DOMI};
            end
            csr_rvalid_o <= 1'b0;
            csr_err_o    <= 1'b0;
            csr_rdata_o  <= '0;
        end else begin
            if (accept && csr_we_i && !err_c) begin
                case (csr_sel_i)
                    SEL_PMPADDR: addr_q[csr_idx_i] <= csr_wdata_i;
                    SEL_PMPCFG:  cfg_q[csr_idx_i]  <= pmpcfg_t'(csr_wdata_i[7:0]);
                    SEL_DMPCFG:  dmp_q[csr_idx_i]  <= '{domain: dmp_domain_t'(csr_wdata_i[1:0])};
                    default: ;
                endcase
            end
            csr_rvalid_o <= accept;
            csr_err_o    <= accept && err_c;
            csr_rdata_o  <= (accept && !csr_we_i) ? rd_val : '0;
        end
    end

    assign drain_done = cnt_zero && !mem_req_i;

`ifdef DMP_DRAIN_TIMEOUT_EN
    localparam int TMR_W = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
    logic [TMR_W-1:0] tmr_q;
    logic             to_q;

    assign timeout_hit   = (state_q == ST_DRAIN) && !drain_done && (tmr_q == TMR_W'(TIMEOUT - 1));
    assign dsw_timeout_o = (state_q == ST_SWITCH) && to_q;

    // to_q remembers why DRAIN was left so the flag lines up with dsw_ready_o.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            tmr_q <= '0;
            to_q  <= 1'b0;
        end else begin
            tmr_q <= (state_q == ST_DRAIN) ? tmr_q + 1'b1 : '0;
            if (state_q == ST_DRAIN) begin
                to_q <= timeout_hit;
            end else if (state_q != ST_SWITCH) begin
                to_q <= 1'b0;
            end
        end
    end
`else
    assign timeout_hit = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (dsw_valid_i) begin
                    state_d = (dsw_dom_i == expdom_q) ? ST_SWITCH : ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (drain_done || timeout_hit) begin
                    state_d = ST_SWITCH;
                end
            end
            ST_SWITCH: state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= ST_IDLE;
            dom_q    <= DOMI;
            expdom_q <= DOMI;
        end else begin
            state_q <= state_d;
            if (state_q == ST_IDLE && dsw_valid_i) begin
                dom_q <= dsw_dom_i;
            end
            if (state_q == ST_SWITCH) begin
                expdom_q <= dom_q;
            end
        end
    end

    assign dsw_ready_o = (state_q == ST_SWITCH);
    assign expdom_o    = expdom_q;

    for (genvar g = 0; g < NR_ENTRIES; g++) begin : g_out
        assign conf_addr_o[g*PMP_LEN +: PMP_LEN] = addr_q[g];
        assign pmpconf_o[g]                      = cfg_q[g];
        assign dmpconf_o[g]                      = dmp_q[g];
    end

endmodule
